// File: rtl/leb128_pkg.sv
// Shared types and constants for the LEB128 byte-stream encoder.
package leb128_pkg;

    localparam int LEB_MAX_BYTES_I32 = 5;
    localparam int LEB_MAX_BYTES_I64 = 10;
    localparam int LEB_IDX_W = $clog2(LEB_MAX_BYTES_I64);

    localparam logic TYPE_I32 = 1'b0;
    localparam logic TYPE_I64 = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } leb_state_t;

    typedef struct packed {
        logic [6:0]  low;
        logic [63:0] rest;
        logic        done;
    } leb_step_t;

    function automatic logic [63:0] leb_extend_i32(
        input logic [31:0] d,
        input logic        sgn
    );
        return sgn ? {{32{d[31]}}, d} : {32'd0, d};
    endfunction

endpackage

// File: rtl/leb128_step.sv
// One LEB128 step: split the working value into the next 7-bit group
// and the remainder, and decide whether this group terminates the value.
module leb128_step
    import leb128_pkg::*;
(
    input  logic [63:0] val,
    input  logic        sgn,
    output leb_step_t   step
);

    logic [63:0] rest;
    logic        rest_zero;
    logic        rest_ones;

    always_comb begin
        rest      = sgn ? 64'($signed(val) >>> 7) : (val >> 7);
        rest_zero = (rest == 64'd0);
        rest_ones = (rest == {64{1'b1}});
        step.low  = val[6:0];
        step.rest = rest;
        // Signed stops once the remainder is pure sign matching bit 6.
        unique case (1'b1)
            !sgn:    step.done = rest_zero;
            default: step.done = (rest_zero && !val[6]) ||
                                 (rest_ones &&  val[6]);
        endcase
    end

endmodule

// File: rtl/leb128_encoder.sv
// Streaming ULEB128/SLEB128 encoder: one i32/i64 value in, its
// minimal-length byte sequence out over a valid/ready stream.
module leb128_encoder
    import leb128_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    input  logic             in_is64,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic [3:0]       out_index
);

    leb_state_t           state, state_d;
    logic [63:0]          val, val_d;
    logic                 sgn, sgn_d;
    logic [LEB_IDX_W-1:0] idx, idx_d;
    leb_step_t            step;

    leb128_step u_step (
        .val  (val),
        .sgn  (sgn),
        .step (step)
    );

    always_comb begin
        in_ready  = (state == ST_IDLE) && !reset;
        out_valid = (state == ST_EMIT);
        out_byte  = out_valid ? {~step.done, step.low} : 8'h00;
        out_last  = out_valid && step.done;
        out_index = idx;
    end

    always_comb begin
        state_d = state;
        val_d   = val;
        sgn_d   = sgn;
        idx_d   = idx;
        unique case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    val_d   = (in_is64 == TYPE_I64) ? in_data :
                              leb_extend_i32(in_data[31:0], in_signed);
                    sgn_d   = in_signed;
                    idx_d   = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (step.done) begin
                        state_d = ST_IDLE;
                    end else begin
                        val_d = step.rest;
                        idx_d = idx + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            val   <= 64'd0;
            sgn   <= 1'b0;
            idx   <= '0;
        end else begin
            state <= state_d;
            val   <= val_d;
            sgn   <= sgn_d;
            idx   <= idx_d;
        end
    end

endmodule

// File: tb/tb_leb128_encoder.sv
// Directed and randomised checks of the LEB128 stream encoder.
module tb_leb128_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_signed;
    logic        in_is64;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic [3:0]  out_index;

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    logic [7:0] got_b[$];
    logic       got_l[$];
    logic [3:0] got_i[$];
    bit         got_to;

    typedef struct packed {
        logic [63:0] d;
        logic        s;
        logic        w;
        logic [3:0]  n;
        logic [79:0] b;
    } vec_t;

    always #5 clk = ~clk;

    always @(negedge clk)
        if (in_ready && out_valid) overlap++;

    leb128_encoder #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_is64   (in_is64),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .out_index (out_index)
    );

    // Offer one value, then consume every byte with out_ready held high.
    task automatic collect(input logic [63:0] d, input logic s,
                           input logic w);
        bit fin;
        int n;
        got_b.delete(); got_l.delete(); got_i.delete();
        got_to = 0; fin = 0; n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1; in_data = d; in_signed = s; in_is64 = w;
        out_ready = 1;
        @(negedge clk);
        in_valid = 0; in_data = ~d; in_signed = ~s; in_is64 = ~w;
        n = 0;
        while (!fin && n < 16) begin
            if (out_valid) begin
                got_b.push_back(out_byte);
                got_l.push_back(out_last);
                got_i.push_back(out_index);
                fin = out_last;
            end
            @(negedge clk);
            n++;
        end
        got_to = !fin;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 0; in_data = '0;
        in_signed = 0; in_is64 = 0; out_ready = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if ({out_valid, out_byte, out_last, out_index} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b b=%h l=%b i=%0d exp 0",
                     out_valid, out_byte, out_last, out_index);
        end
        reset = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic();
        vec_t v[3];
        logic [79:0] bb;
        v[0] = '{64'd624485, 1'b0, 1'b0, 4'd3, 80'h26_8E_E5};
        v[1] = '{64'hFFFF_FFFF_FFFE_1DC0, 1'b1, 1'b1, 4'd3,
                 80'h78_BB_C0};
        v[2] = '{64'd42, 1'b1, 1'b0, 4'd1, 80'h2A};
        for (int t = 0; t < 3; t++) begin
            collect(v[t].d, v[t].s, v[t].w);
            bb = v[t].b;
            checks++;
            if (got_to || got_b.size() != int'(v[t].n)) begin
                errors++;
                $display("FAIL basic%0d_len got=%0d exp=%0d to=%0b",
                         t, got_b.size(), v[t].n, got_to);
            end else begin
                for (int i = 0; i < got_b.size(); i++) begin
                    checks++;
                    if (got_b[i] !== bb[8*i +: 8] ||
                        got_l[i] !== (i == int'(v[t].n) - 1) ||
                        got_i[i] !== 4'(i)) begin
                        errors++;
                        $display("FAIL basic%0d_byte%0d got=%h/%b/%0d exp=%h/%b/%0d",
                                 t, i, got_b[i], got_l[i], got_i[i],
                                 bb[8*i +: 8], i == int'(v[t].n) - 1, i);
                    end
                end
            end
        end
    endtask

    task automatic test_boundaries();
        vec_t v[4];
        logic [79:0] bb;
        v[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 4'd10,
                 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF};
        v[1] = '{64'h0000_0000_8000_0000, 1'b1, 1'b0, 4'd5,
                 80'h78_80_80_80_80};
        v[2] = '{64'hDEAD_BEEF_0000_0080, 1'b0, 1'b0, 4'd2, 80'h01_80};
        v[3] = '{64'd0, 1'b0, 1'b1, 4'd1, 80'h00};
        for (int t = 0; t < 4; t++) begin
            collect(v[t].d, v[t].s, v[t].w);
            bb = v[t].b;
            checks++;
            if (got_to || got_b.size() != int'(v[t].n)) begin
                errors++;
                $display("FAIL bound%0d_len got=%0d exp=%0d to=%0b",
                         t, got_b.size(), v[t].n, got_to);
            end else begin
                for (int i = 0; i < got_b.size(); i++) begin
                    checks++;
                    if (got_b[i] !== bb[8*i +: 8] ||
                        got_l[i] !== (i == int'(v[t].n) - 1) ||
                        got_i[i] !== 4'(i)) begin
                        errors++;
                        $display("FAIL bound%0d_byte%0d got=%h/%b/%0d exp=%h/%b/%0d",
                                 t, i, got_b[i], got_l[i], got_i[i],
                                 bb[8*i +: 8], i == int'(v[t].n) - 1, i);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] hb;
        logic       hl;
        logic [3:0] hi;
        logic [23:0] seq;
        bit fin;
        int n;
        @(negedge clk);
        in_valid = 1; in_data = 64'd624485; in_signed = 0; in_is64 = 0;
        out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        seq = '0; fin = 0; n = 0;
        seq[7:0] = out_byte;
        @(negedge clk);
        out_ready = 0;
        hb = out_byte; hl = out_last; hi = out_index;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_byte !== hb ||
                out_last !== hl || out_index !== hi) begin
                errors++;
                $display("FAIL bp_hold%0d got=%b/%h/%b/%0d exp=1/%h/%b/%0d",
                         c, out_valid, out_byte, out_last, out_index,
                         hb, hl, hi);
            end
        end
        out_ready = 1;
        while (!fin && n < 10) begin
            if (out_valid) begin
                seq[8*int'(out_index) +: 8] = out_byte;
                fin = out_last;
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (!fin || seq !== 24'h26_8E_E5 || hb !== 8'h8E || hi !== 4'd1) begin
            errors++;
            $display("FAIL bp_stream got=%h held=%h/%0d exp=268ee5 held=8e/1",
                     seq, hb, hi);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1; in_data = 64'h8000_0000; in_signed = 1; in_is64 = 0;
        out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_during got v=%b r=%b exp v=0 r=0",
                     out_valid, in_ready);
        end
        reset = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_after got v=%b r=%b exp v=0 r=1",
                     out_valid, in_ready);
        end
        collect(64'd42, 1'b1, 1'b0);
        checks++;
        if (got_to || got_b.size() != 1 || got_b[0] !== 8'h2A ||
            got_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_next got n=%0d b=%h exp n=1 b=2a",
                     got_b.size(), got_b.size() > 0 ? got_b[0] : 8'hxx);
        end
    endtask

    task automatic test_random();
        logic [63:0] d, acc, expv;
        logic s, w;
        int sh, k, n;
        bit fin, bad;
        for (int t = 0; t < 100; t++) begin
            d = {$urandom, $urandom} >> $urandom_range(0, 63);
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) d = ~d;
            expv = w ? d : (s ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]});
            @(negedge clk);
            n = 0;
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            in_valid = 1; in_data = d; in_signed = s; in_is64 = w;
            out_ready = 1;
            @(negedge clk);
            in_valid = 0;
            acc = '0; sh = 0; k = 0; n = 0; fin = 0; bad = 0;
            while (!fin && n < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    acc |= 64'(out_byte[6:0]) << sh;
                    if (out_index !== 4'(k) || out_byte[7] !== !out_last)
                        bad = 1;
                    sh += 7;
                    k++;
                    fin = out_last;
                    if (fin && s && sh < 64 && out_byte[6])
                        acc |= {64{1'b1}} << sh;
                end
                @(negedge clk);
                n++;
            end
            checks++;
            if (!fin || bad || acc !== expv || k > (w ? 10 : 5)) begin
                errors++;
                $display("FAIL rand%0d got=%h n=%0d bad=%0b exp=%h s=%b w=%b",
                         t, acc, k, bad, expv, s, w);
            end
        end
        out_ready = 1;
    endtask

    task automatic test_overlap();
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL ready_valid_overlap got=%0d exp=0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leb128_encoder.md
# leb128_encoder

Streaming LEB128 encoder, the write-side counterpart of the CPU's immediate decoder. Accepts one i32/i64 value per transaction, signed or unsigned, and emits its minimal-length LEB128 byte sequence over a valid/ready byte stream. Used by the bytecode emitter and test infrastructure to build ROM images and to feed the CPU's `mem_data` path with encoded immediates.

## Interface

- `WIDTH`, default 64: value width. Only 64 is supported; the i32 mode is selected per transaction.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  an input value is offered.
- `in_ready`  out  1  the encoder can accept a value; high only in IDLE.
- `in_data`  in  64  value; in i32 mode only `[31:0]` is used.
- `in_signed`  in  1  1 = SLEB128, 0 = ULEB128.
- `in_is64`  in  1  1 = i64 value, 0 = i32 value.
- `out_valid`  out  1  `out_byte` is valid.
- `out_ready`  in  1  the consumer takes the byte.
- `out_byte`  out  8  encoded byte; bit 7 is the continuation flag.
- `out_last`  out  1  the current byte is the final byte of the value.
- `out_index`  out  4  position of the current byte within the value (0..9).

## Operation

- States: IDLE, EMIT.
- **IDLE:** `in_ready` is 1. On `in_valid & in_ready`:
  - latch `val`, the 64-bit working value;
  - for i32, `val` = `in_data[31:0]` sign-extended when signed, zero-extended when unsigned; bits `[63:32]` of `in_data` are ignored;
  - latch the `signed` flag, clear the index and go to EMIT.
- **EMIT:** the current byte is formed from `val` as follows.
  - `low` = `val[6:0]`.
  - `rest` = `val >>> 7` when signed, `val >> 7` when unsigned.
  - Unsigned: `done` = (`rest` == 0).
  - Signed: `done` = (`rest` == 0 and `low[6]` == 0) or (`rest` == all-ones and `low[6]` == 1).
  - `out_byte` = {~`done`, `low`}; `out_last` = `done`; `out_valid` = 1.
- **Handshake:** on `out_valid & out_ready`:
  - if `done`, go to IDLE;
  - otherwise `val` ← `rest` and `out_index` increments.
- **Holding:** while `out_ready` = 0, `out_byte`, `out_last` and `out_index` hold stable.
- **Maximum length:** the byte count never exceeds 5 for i32 or 10 for i64. The `done` logic guarantees this; no separate length check is needed.
- **Register reset values:** IDLE, `out_valid` 0, `out_byte` 0x00, `out_last` 0, `out_index` 0, `val` 0.
- **`in_ready` during reset:** `in_ready` is 0 while `reset` is high.
- **Reset mid-sequence:** the remaining bytes are discarded with no partial completion. `out_valid` is 0 in the cycle after the reset edge.
- **Undefined input:** `in_signed` and `in_is64` are sampled only at acceptance.

## Timing

- Acceptance edge to first `out_valid`: 1 cycle (registered output).
- Sustained throughput: 1 byte per cycle while `out_ready` = 1.
- An N-byte value occupies N EMIT cycles, followed by 1 IDLE cycle before the next acceptance. Minimum transaction period is N+1 cycles.
- `in_ready` and `out_valid` are never high in the same cycle.
- The last-byte handshake and the next `in_valid` are never accepted in the same cycle; acceptance waits for IDLE.

## Structure

- Shared header `leb128.vh`: `LEB_MAX_BYTES_I32` (5), `LEB_MAX_BYTES_I64` (10) and the state encodings.
- The value type selection reuses the existing `i32`/`i64` defines from `cpu.vh`; the mapping is `in_is64` = (type == `i64`).
- Sub-module `leb128_step` is combinational. It takes `val` and `signed` and returns `low`, `rest` and `done`, so the byte-forming logic can be tested in isolation.

## Test plan

- Unsigned i32 624485 → `E5 8E 26`; `out_last` on the third byte only; `out_index` 0, 1, 2.
- Signed i64 -123456 → `C0 BB 78`. Signed i32 42 → single byte `2A` with `out_last` = 1.
- Unsigned i64 0xFFFF_FFFF_FFFF_FFFF → nine `FF` then `01`, `out_index` 9 on the last byte. Signed i32 0x8000_0000 → `80 80 80 80 78`.
- Unsigned i32 with `in_data` = 0xDEAD_BEEF_0000_0080 → `80 01`, confirming the upper bits are ignored. Unsigned 0 → `00`, last.
- Backpressure: `out_ready` held low for 3 cycles mid-sequence → byte, `out_last` and index are stable, and no bytes are lost or duplicated. A random `out_ready` pattern over 100 random values → the decoded stream equals the inputs.
- Reset asserted after the second byte of a 5-byte value → next cycle `out_valid` 0 and `in_ready` 1. The following value `2A` encodes correctly.
